load_ext_unit: RTL and testbench

- Load-side counterpart of the store byte-enable path in the MIPS data-memory interface.
- Accepts one load request at a time from the MEM stage and issues a word-aligned read to data memory.
- Waits for the memory response, then extracts the addressed byte, halfword or word and sign- or zero-extends it to 32 bits.
- Flags misaligned accesses and memory timeouts; drives busy so the hazard unit can stall the pipeline.

---
 rtl/load_ext_unit.sv | 172 +++++++++++++++++
 tb/tb_load_ext_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_ext_unit.sv
// Load extension unit: issues word-aligned data-memory reads for MEM-stage loads
// and returns the addressed byte/halfword/word sign- or zero-extended to 32 bits.
module load_ext_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [2:0]  loadOp,
    output logic        mem_rd_en,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        busy
);

    localparam logic [2:0] OP_LB  = 3'd1;
    localparam logic [2:0] OP_LBU = 3'd2;
    localparam logic [2:0] OP_LH  = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_LW  = 3'd5;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        rd_en_q, rd_en_d;
    logic [31:0] maddr_q, maddr_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rerr_q, rerr_d;

    logic        op_byte;
    logic        op_half;
    logic        op_word;
    logic        is_load;
    logic        misalign;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ext_data;

    // Request decode, evaluated on the live request in IDLE
    assign op_byte  = (loadOp == OP_LB) || (loadOp == OP_LBU);
    assign op_half  = (loadOp == OP_LH) || (loadOp == OP_LHU);
    assign op_word  = (loadOp == OP_LW);
    assign is_load  = op_byte || op_half || op_word;
    assign misalign = (op_half && req_addr[0]) ||
                      (op_word && (req_addr[1:0] != 2'b00));

    always_comb begin
        byte_sel = mem_rdata[7:0];
        unique case (off_q)
            2'd0: byte_sel = mem_rdata[7:0];
            2'd1: byte_sel = mem_rdata[15:8];
            2'd2: byte_sel = mem_rdata[23:16];
            2'd3: byte_sel = mem_rdata[31:24];
        endcase
    end

    assign half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        ext_data = mem_rdata;
        case (op_q)
            OP_LB:   ext_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  ext_data = {24'h0, byte_sel};
            OP_LH:   ext_data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  ext_data = {16'h0, half_sel};
            OP_LW:   ext_data = mem_rdata;
            default: ext_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        off_d    = off_q;
        cnt_d    = cnt_q;
        rd_en_d  = 1'b0;
        maddr_d  = maddr_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        rerr_d   = rerr_q;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid && is_load) begin
                    op_d  = loadOp;
                    off_d = req_addr[1:0];
                    cnt_d = 8'd0;
                    if (misalign) begin
                        state_d  = S_RESP;
                        rvalid_d = 1'b1;
                        rdata_d  = 32'h0;
                        rerr_d   = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        rd_en_d = 1'b1;
                        maddr_d = {req_addr[31:2], 2'b00};
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                // A response landing in the timeout cycle still wins
                if (mem_rvalid) begin
                    state_d  = S_RESP;
                    rvalid_d = 1'b1;
                    rdata_d  = ext_data;
                    rerr_d   = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = S_RESP;
                    rvalid_d = 1'b1;
                    rdata_d  = 32'h0;
                    rerr_d   = 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= 3'd0;
            off_q    <= 2'd0;
            cnt_q    <= 8'd0;
            rd_en_q  <= 1'b0;
            maddr_q  <= 32'h0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'h0;
            rerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            off_q    <= off_d;
            cnt_q    <= cnt_d;
            rd_en_q  <= rd_en_d;
            maddr_q  <= maddr_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rerr_q   <= rerr_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q == S_WAIT) || (state_q == S_RESP);
    assign mem_rd_en = rd_en_q;
    assign mem_addr  = maddr_q;
    assign rsp_valid = rvalid_q;
    assign rsp_data  = rdata_q;
    assign rsp_err   = rerr_q;

endmodule

// File: tb/tb_load_ext_unit.sv
// Bench for load_ext_unit: directed table, random loads against an arithmetic
// reference model, and hand sequences for reset abort and ignored requests.
module tb_load_ext_unit;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [2:0]  loadOp;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;

    int total = 0;
    int bad   = 0;

    load_ext_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .loadOp     (loadOp),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] rdata;
        int          lat;
        logic [31:0] d;
        logic        e;
        int          k;
    } vec_t;

    vec_t tbl[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Reference: size/offset arithmetic, lat = WAIT-cycle index of rvalid
    function automatic void model(input logic [2:0] op, input logic [31:0] addr,
                                  input logic [31:0] rdata, input int lat,
                                  output logic [31:0] d, output logic e,
                                  output int k);
        longint size, off, v, lim;
        size = (op <= 3'd2) ? 1 : (op <= 3'd4) ? 2 : 4;
        off  = longint'(addr) % 4;
        d = 32'h0;
        e = 1'b1;
        k = 0;
        if ((longint'(addr) % size) != 0) return;
        k = TIMEOUT;
        if (lat < 0 || lat >= TIMEOUT) return;
        lim = 64'd1 << (8 * size);
        v = (longint'(rdata) >> (8 * off)) % lim;
        if ((op == 3'd1 || op == 3'd3) && v >= lim / 2) v = v - lim;
        d = v[31:0];
        e = 1'b0;
        k = lat + 1;
    endfunction

    task automatic run_load(input string tag, input logic [2:0] op,
                            input logic [31:0] addr, input logic [31:0] rdata,
                            input int lat, input logic [31:0] exp_d,
                            input logic exp_e, input int exp_k);
        int          k_seen = -1;
        int          rd_cnt = 0;
        logic [31:0] seen_addr = 32'h0;
        logic        busy_ok = 1'b1;
        logic [31:0] d = 32'h0;
        logic        e = 1'b0;
        chk({tag, ".ready"}, {31'h0, req_ready}, 32'd1);
        req_valid = 1'b1;
        loadOp    = op;
        req_addr  = addr;
        tick();
        req_valid = 1'b0;
        loadOp    = 3'd0;
        req_addr  = $urandom;
        for (int k = 0; k < 40; k++) begin
            if (mem_rd_en) begin
                rd_cnt++;
                seen_addr = mem_addr;
            end
            if (!busy) busy_ok = 1'b0;
            if (rsp_valid) begin
                k_seen = k;
                d = rsp_data;
                e = rsp_err;
                break;
            end
            mem_rvalid = (k == lat);
            mem_rdata  = (k == lat) ? rdata : $urandom;
            tick();
        end
        mem_rvalid = 1'b0;
        chk({tag, ".lat"}, k_seen, exp_k);
        chk({tag, ".rd_cnt"}, rd_cnt, (exp_k == 0) ? 0 : 1);
        if (exp_k != 0) chk({tag, ".mem_addr"}, seen_addr, addr & ~32'h3);
        chk({tag, ".data"}, d, exp_d);
        chk({tag, ".err"}, {31'h0, e}, {31'h0, exp_e});
        chk({tag, ".busy"}, {31'h0, busy_ok}, 32'd1);
        tick();
        chk({tag, ".pulse"}, {31'h0, rsp_valid}, 32'd0);
        chk({tag, ".idle"}, {31'h0, req_ready}, 32'd1);
        chk({tag, ".hold"}, rsp_data, d);
    endtask

    initial begin
        logic [31:0] md;
        logic        me;
        int          mk;
        logic [2:0]  rop;
        logic [31:0] raddr, rdat;
        int          rlat;

        tbl[0] = '{3'd1, 32'h0000_1003, 32'h80FF_1234, 1, 32'hFFFF_FF80, 1'b0, 2};
        tbl[1] = '{3'd4, 32'h0000_2002, 32'h8001_F00F, 0, 32'h0000_8001, 1'b0, 1};
        tbl[2] = '{3'd3, 32'h0000_2000, 32'h8001_F00F, 0, 32'hFFFF_F00F, 1'b0, 1};
        tbl[3] = '{3'd5, 32'h0000_0004, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1'b0, 1};
        tbl[4] = '{3'd5, 32'h0000_0006, 32'h1111_1111, 0, 32'h0, 1'b1, 0};
        tbl[5] = '{3'd3, 32'h0000_0001, 32'h2222_2222, 0, 32'h0, 1'b1, 0};
        tbl[6] = '{3'd2, 32'h0000_0010, 32'h3333_3333, -1, 32'h0, 1'b1, 4};
        tbl[7] = '{3'd2, 32'h0000_0011, 32'h0000_AB00, 3, 32'h0000_00AB, 1'b0, 4};
        tbl[8] = '{3'd1, 32'h0000_0002, 32'h007F_0000, 2, 32'h0000_007F, 1'b0, 3};
        tbl[9] = '{3'd4, 32'h0000_0003, 32'h4444_4444, 0, 32'h0, 1'b1, 0};

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_addr   = 32'h0;
        loadOp     = 3'd0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.rd_en", {31'h0, mem_rd_en}, 32'd0);
        chk("rst.addr", mem_addr, 32'h0);
        chk("rst.valid", {31'h0, rsp_valid}, 32'd0);
        chk("rst.data", rsp_data, 32'h0);
        chk("rst.err", {31'h0, rsp_err}, 32'd0);
        chk("rst.ready", {31'h0, req_ready}, 32'd1);
        chk("rst.busy", {31'h0, busy}, 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_load($sformatf("vec%0d", i), tbl[i].op, tbl[i].addr,
                     tbl[i].rdata, tbl[i].lat, tbl[i].d, tbl[i].e, tbl[i].k);
        end

        for (int i = 0; i < 60; i++) begin
            rop   = 3'($urandom_range(1, 5));
            raddr = $urandom;
            rdat  = $urandom;
            rlat  = $urandom_range(0, 6);
            model(rop, raddr, rdat, rlat, md, me, mk);
            run_load($sformatf("rnd%0d", i), rop, raddr, rdat, rlat, md, me, mk);
        end

        // No-load opcodes with req_valid are ignored
        for (int j = 0; j < 3; j++) begin
            req_valid = 1'b1;
            loadOp    = (j == 0) ? 3'd0 : (j == 1) ? 3'd6 : 3'd7;
            req_addr  = 32'h0000_0100;
            tick();
            chk($sformatf("noload%0d.rd_en", j), {31'h0, mem_rd_en}, 32'd0);
            chk($sformatf("noload%0d.busy", j), {31'h0, busy}, 32'd0);
            chk($sformatf("noload%0d.ready", j), {31'h0, req_ready}, 32'd1);
        end
        req_valid = 1'b0;
        loadOp    = 3'd0;

        // Reset two cycles after accept, then a late rvalid
        req_valid = 1'b1;
        loadOp    = 3'd2;
        req_addr  = 32'h0000_0200;
        tick();
        req_valid = 1'b0;
        loadOp    = 3'd0;
        chk("abort.rd_en", {31'h0, mem_rd_en}, 32'd1);
        tick();
        chk("abort.busy", {31'h0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("abort.ready", {31'h0, req_ready}, 32'd1);
        chk("abort.nbusy", {31'h0, busy}, 32'd0);
        chk("abort.addr", mem_addr, 32'h0);
        chk("abort.data", rsp_data, 32'h0);
        chk("abort.err", {31'h0, rsp_err}, 32'd0);
        chk("abort.valid", {31'h0, rsp_valid}, 32'd0);
        tick();
        reset      = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        tick();
        mem_rvalid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("late%0d.valid", j), {31'h0, rsp_valid}, 32'd0);
            chk($sformatf("late%0d.rd_en", j), {31'h0, mem_rd_en}, 32'd0);
            tick();
        end
        chk("late.data", rsp_data, 32'h0);

        run_load("post", 3'd5, 32'h0000_0040, 32'hCAFE_F00D, 1,
                 32'hCAFE_F00D, 1'b0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
